latch_out_capture: RTL and testbench
====================================

# latch_out_capture

Clocked capture stage directly downstream of the 3-bit transparent-latch bank. Synchronises the latch outputs into `clk`, filters short glitches per bit, and reports each filtered change as a rise/fall event over a valid/ready handshake. It also maintains a change counter and forms the boundary between the asynchronous latch outputs and the synchronous control logic.

## Interface
- `WIDTH`, 3: number of latch bits captured.
- `SYNC_STAGES`, 2: synchroniser depth; legal values ≥ 2.
- `FILT_CYCLES`, 4: consecutive cycles a synced bit must differ before it is accepted; legal values ≥ 1.
- `RST_VAL`, 3'b010: reset value of the stable image. Matches the latch bank's reset levels: bit1 = 1, others 0.
- `CNT_W`, 8: change counter width.

Ports:
- `clk`, in, 1: capture clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `lat_in`, in, WIDTH: latch outputs; asynchronous to `clk`.
- `stable_out`, out, WIDTH: filtered, synchronous image of `lat_in`.
- `evt_valid`, out, 1: event pending.
- `evt_ready`, in, 1: consumer accepts the event.
- `evt_data`, out, WIDTH: `stable_out` value at the most recent change.
- `evt_rise`, out, WIDTH: bits that went 0→1 since the last accepted event.
- `evt_fall`, out, WIDTH: bits that went 1→0 since the last accepted event.
- `evt_ovf`, out, 1: more than one change was merged into this event.
- `change_cnt`, out, CNT_W: count of cycles in which `stable_out` changed; saturating.

## Operation
- **Synchroniser**
  - Per-bit chain of `SYNC_STAGES` flops.
  - On reset, all stages load `RST_VAL`.
  - `synced` is the last stage.
- **Filter (per bit)**
  - Counter `fc` has width clog2(FILT_CYCLES+1).
  - When `synced[i] != stable_out[i]`, `fc` increments.
  - When `fc` reaches FILT_CYCLES, `stable_out[i]` toggles and `fc` clears on that same edge.
  - When `synced[i] == stable_out[i]`, `fc` clears.
  - A glitch shorter than FILT_CYCLES synced cycles is therefore never reported.
- **Change detect**
  - `chg_rise` = bits of `stable_out` going 0→1 this edge; `chg_fall` = bits going 1→0.
  - `chg` = any bit set in either mask.
- **Event FSM**
  - IDLE
    - On `chg`, load `evt_data`, `evt_rise`, `evt_fall`; clear `evt_ovf`; go to PEND.
  - PEND (`evt_valid`=1)
    - `evt_ready` & !`chg`: clear the masks, go to IDLE.
    - `evt_ready` & `chg`: fresh load as in IDLE (no merge, `evt_ovf`=0), stay in PEND.
    - !`evt_ready` & `chg`: merge.
      - `evt_rise |= chg_rise`, `evt_fall |= chg_fall`.
      - `evt_data` takes the new value.
      - `evt_ovf` is set.
      - Stay in PEND.
    - !`evt_ready` & !`chg`: hold all event outputs stable.
  - A bit can appear in both `evt_rise` and `evt_fall` after a merge. This is legal.
- **Handshake**
  - A transfer occurs on an edge with `evt_valid` & `evt_ready`.
  - `evt_valid` never drops without a transfer, except on reset.
  - `evt_ready` is permitted while `evt_valid`=0 and has no effect.
- **Reset values**
  - `stable_out`=RST_VAL, `evt_data`=RST_VAL.
  - `evt_valid`=0, `evt_rise`=0, `evt_fall`=0, `evt_ovf`=0, `change_cnt`=0.
  - All `fc`=0; FSM = IDLE.
- **Reset mid-event**: a pending event is discarded and no transfer is reported.

## Timing
- If `lat_in[i]` changes before edge k and then holds:
  - `stable_out[i]` and `evt_valid` rise after edge k+SYNC_STAGES+FILT_CYCLES-1.
  - With defaults, that is edge k+5.
- Event outputs are registered and change only on `clk` edges.
- `change_cnt` updates on the same edge as `stable_out`.
- Simultaneous changes on several bits in one cycle produce one event with several mask bits set. `change_cnt` counts this as +1.

## Configuration
- Macro: `LATCH_CAPTURE_CHANGE_CNT_EN`.
- Defined:
  - `change_cnt` increments by 1 on every edge where `chg`=1.
  - Saturates at 2^CNT_W-1 and is cleared only by reset.
- Undefined:
  - The counter logic is omitted.
  - `change_cnt` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset**
  - Stimulus: assert `reset` for 2 cycles with `lat_in`=3'b010.
  - Response: `stable_out`=3'b010, `evt_valid`=0, masks 0, `change_cnt`=0, and no event after release.
- **Single rise**
  - Stimulus: `lat_in` 3'b010→3'b011 before edge k, held; `evt_ready`=1.
  - Response: `evt_valid`=1 at edge k+5 with `evt_rise`=3'b001, `evt_fall`=0, `evt_data`=3'b011; `evt_valid`=0 at k+6.
- **Glitch rejection**
  - Stimulus: `lat_in[0]` pulses high for 3 cycles.
  - Response: `stable_out` unchanged, no `evt_valid`, `change_cnt` unchanged.
- **Merge / backpressure**
  - Stimulus: `evt_ready`=0; bit0 rises, then 10 cycles later bit1 falls.
  - Response: one event with `evt_rise`=3'b001, `evt_fall`=3'b010, `evt_data`=3'b001, `evt_ovf`=1. Outputs stay stable until `evt_ready`=1, then `evt_valid` drops.
- **Accept with new change on the same edge**
  - Stimulus: `evt_ready`=1 on the edge where bit2 becomes stable at 1.
  - Response: the old event transfers; a new event follows with `evt_rise`=3'b100 and `evt_ovf`=0; `evt_valid` stays 1.
- **Counter saturation (macro defined, `CNT_W`=2)**
  - Stimulus: 5 filtered changes.
  - Response: `change_cnt` reads 1, 2, 3, 3, 3. With the macro undefined, it reads 0 throughout.

Source files
------------

// File: rtl/latch_out_capture.sv
// Capture stage for the latch bank: synchronises, de-glitches and reports bit changes as rise/fall events. Optional change counter: LATCH_CAPTURE_CHANGE_CNT_EN.
// Latency: a held input change appears on stable_out/evt_valid SYNC_STAGES+FILT_CYCLES-1 edges after it is first sampled.
// Backpressure: while evt_ready is low, new changes merge into the pending event (masks OR-ed, evt_ovf set); nothing is dropped.
module latch_out_capture #(
    parameter int               WIDTH       = 3,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = WIDTH'(3'b010),
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] lat_in,
    output logic [WIDTH-1:0] stable_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic [WIDTH-1:0] evt_rise,
    output logic [WIDTH-1:0] evt_fall,
    output logic             evt_ovf,
    output logic [CNT_W-1:0] change_cnt
);

    localparam int              FC_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [FC_W-1:0]  fc_q [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] chg_rise;
    logic [WIDTH-1:0] chg_fall;
    logic             chg;
    state_t           state;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VAL;
        end else begin
            sync_q[0] <= lat_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // A bit flips on the FILT_CYCLES-th consecutive edge of disagreement.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = (synced[i] != stable_q[i]) && (fc_q[i] == FC_LAST);
        end
        stable_nxt = stable_q ^ toggle;
        chg_rise   = stable_nxt & ~stable_q;
        chg_fall   = ~stable_nxt & stable_q;
        chg        = |(chg_rise | chg_fall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) fc_q[i] <= '0;
        end else begin
            stable_q <= stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                if (synced[i] == stable_q[i] || toggle[i]) begin
                    fc_q[i] <= '0;
                end else begin
                    fc_q[i] <= fc_q[i] + FC_W'(1);
                end
            end
        end
    end

    assign stable_out = stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_data  <= RST_VAL;
            evt_rise  <= '0;
            evt_fall  <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (chg) begin
                        state     <= ST_PEND;
                        evt_valid <= 1'b1;
                        evt_data  <= stable_nxt;
                        evt_rise  <= chg_rise;
                        evt_fall  <= chg_fall;
                        evt_ovf   <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (evt_ready) begin
                        if (chg) begin
                            evt_data <= stable_nxt;
                            evt_rise <= chg_rise;
                            evt_fall <= chg_fall;
                            evt_ovf  <= 1'b0;
                        end else begin
                            state     <= ST_IDLE;
                            evt_valid <= 1'b0;
                            evt_rise  <= '0;
                            evt_fall  <= '0;
                            evt_ovf   <= 1'b0;
                        end
                    end else if (chg) begin
                        // Consumer stalled: accumulate so no edge is lost.
                        evt_data <= stable_nxt;
                        evt_rise <= evt_rise | chg_rise;
                        evt_fall <= evt_fall | chg_fall;
                        evt_ovf  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LATCH_CAPTURE_CHANGE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (chg && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign change_cnt = cnt_q;
`else
    assign change_cnt = '0;
`endif

endmodule

// File: tb/tb_latch_out_capture.sv
// Bench for latch_out_capture: directed scenarios with literal expectations plus randomized traffic against a history-based model.
module tb_latch_out_capture;
    localparam int         W    = 3;
    localparam int         SS   = 2;
    localparam int         FC   = 4;
    localparam int         CW   = 2;
    localparam logic [2:0] RV   = 3'b010;
    localparam int         MAXE = 8192;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  lat_in = RV;
    logic          evt_ready = 1'b0;
    logic [W-1:0]  stable_out, evt_data, evt_rise, evt_fall;
    logic          evt_valid, evt_ovf;
    logic [CW-1:0] change_cnt;

    always #5 clk = ~clk;

    latch_out_capture #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .RST_VAL(RV), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .lat_in(lat_in), .stable_out(stable_out),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .evt_rise(evt_rise), .evt_fall(evt_fall), .evt_ovf(evt_ovf), .change_cnt(change_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ec(input int v);
`ifdef LATCH_CAPTURE_CHANGE_CNT_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Reference model: a bit is accepted once the synchronised input (the input
    // delayed SS edges) has disagreed with it on each of the last FC edges, all
    // of them after the bit last flipped.
    logic [W-1:0] m_stable, m_data, m_rise, m_fall;
    logic         m_valid, m_ovf;
    logic [CW-1:0] m_cnt;
    logic [W-1:0] lat_hist [MAXE];
    logic [W-1:0] syn_hist [MAXE];
    int           last_tog [W];
    int           n;
    bit           model_ok = 0;

    initial begin
        logic [W-1:0] syn, nw, r, f;
        bit all_diff;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_stable = RV; m_data = RV; m_valid = 0; m_rise = 0; m_fall = 0;
                m_ovf = 0; m_cnt = 0; n = 0; model_ok = 1;
                for (int i = 0; i < W; i++) last_tog[i] = -1;
            end else begin
                if (n >= MAXE) begin
                    $display("FAIL model_history: got %0d edges, limit %0d", n, MAXE);
                    $fatal(1, "model history exhausted");
                end
                lat_hist[n] = lat_in;
                syn = (n >= SS) ? lat_hist[n-SS] : RV;
                syn_hist[n] = syn;
                nw = m_stable;
                for (int i = 0; i < W; i++) begin
                    if (n - FC + 1 > last_tog[i]) begin
                        all_diff = 1;
                        for (int j = n - FC + 1; j <= n; j++)
                            if (syn_hist[j][i] == m_stable[i]) all_diff = 0;
                        if (all_diff) begin
                            nw[i] = ~m_stable[i];
                            last_tog[i] = n;
                        end
                    end
                end
                r = nw & ~m_stable;
                f = m_stable & ~nw;
                if ((r | f) != 0) begin
`ifdef LATCH_CAPTURE_CHANGE_CNT_EN
                    if (m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
`endif
                    if (!m_valid || evt_ready) begin
                        m_rise = r; m_fall = f; m_ovf = 0;
                    end else begin
                        m_rise = m_rise | r; m_fall = m_fall | f; m_ovf = 1;
                    end
                    m_data = nw;
                    m_valid = 1;
                end else if (m_valid && evt_ready) begin
                    m_valid = 0; m_rise = 0; m_fall = 0; m_ovf = 0;
                end
                m_stable = nw;
                n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok)
                chk("cycle {stable,valid,data,rise,fall,ovf,cnt}",
                    32'({stable_out, evt_valid, evt_data, evt_rise, evt_fall, evt_ovf, change_cnt}),
                    32'({m_stable, m_valid, m_data, m_rise, m_fall, m_ovf, m_cnt}));
        end
    end

    int hold;

    initial begin
        // Reset
        cyc(2);
        chk("rst_stable", 32'(stable_out), 32'(3'b010));
        chk("rst_valid", 32'(evt_valid), 32'(0));
        chk("rst_masks", 32'({evt_rise, evt_fall, evt_ovf}), 32'(0));
        chk("rst_cnt", 32'(change_cnt), 32'(0));
        reset = 0;
        cyc(8);
        chk("no_evt_after_rst", 32'(evt_valid), 32'(0));

        // Single rise, consumer always ready
        evt_ready = 1; lat_in = 3'b011;
        cyc(5);
        chk("rise_not_yet", 32'(evt_valid), 32'(0));
        cyc(1);
        chk("rise_valid", 32'(evt_valid), 32'(1));
        chk("rise_masks", 32'({evt_rise, evt_fall}), 32'({3'b001, 3'b000}));
        chk("rise_data", 32'(evt_data), 32'(3'b011));
        chk("rise_cnt", 32'(change_cnt), ec(1));
        cyc(1);
        chk("rise_done", 32'(evt_valid), 32'(0));

        // Glitch rejection
        reset = 1; evt_ready = 0; lat_in = RV;
        cyc(2);
        reset = 0;
        cyc(3);
        lat_in = 3'b011;
        cyc(3);
        lat_in = 3'b010;
        cyc(12);
        chk("glitch_stable", 32'(stable_out), 32'(3'b010));
        chk("glitch_valid", 32'(evt_valid), 32'(0));
        chk("glitch_cnt", 32'(change_cnt), ec(0));

        // Merge under backpressure
        lat_in = 3'b011;
        cyc(6);
        chk("merge_first", 32'({evt_valid, evt_rise}), 32'({1'b1, 3'b001}));
        chk("cnt_1", 32'(change_cnt), ec(1));
        cyc(4);
        lat_in = 3'b001;
        cyc(6);
        chk("merge_evt", 32'({evt_valid, evt_rise, evt_fall, evt_data, evt_ovf}),
            32'({1'b1, 3'b001, 3'b010, 3'b001, 1'b1}));
        chk("cnt_2", 32'(change_cnt), ec(2));
        cyc(5);
        chk("merge_hold", 32'({evt_valid, evt_rise, evt_fall, evt_data, evt_ovf}),
            32'({1'b1, 3'b001, 3'b010, 3'b001, 1'b1}));
        evt_ready = 1;
        cyc(1);
        chk("merge_xfer", 32'(evt_valid), 32'(0));
        evt_ready = 0;

        // Accept on the same edge as a new change
        lat_in = 3'b000;
        cyc(6);
        chk("pend_fall", 32'({evt_valid, evt_fall}), 32'({1'b1, 3'b001}));
        chk("cnt_3", 32'(change_cnt), ec(3));
        lat_in = 3'b100;
        cyc(5);
        chk("pend_still", 32'({evt_valid, evt_fall}), 32'({1'b1, 3'b001}));
        evt_ready = 1;
        cyc(1);
        chk("fresh_evt", 32'({evt_valid, evt_rise, evt_fall, evt_data, evt_ovf}),
            32'({1'b1, 3'b100, 3'b000, 3'b100, 1'b0}));
        chk("cnt_sat_a", 32'(change_cnt), ec(3));
        cyc(1);
        chk("fresh_xfer", 32'(evt_valid), 32'(0));
        lat_in = 3'b110;
        cyc(6);
        chk("cnt_sat_b", 32'(change_cnt), ec(3));

        // Reset with an event pending
        evt_ready = 0; lat_in = 3'b010;
        cyc(6);
        chk("pend_before_rst", 32'(evt_valid), 32'(1));
        reset = 1;
        cyc(1);
        chk("rst_discard", 32'(evt_valid), 32'(0));
        reset = 0;
        cyc(10);
        chk("rst_discard_quiet", 32'(evt_valid), 32'(0));

        // Randomized traffic
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                lat_in = 3'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            evt_ready = (c % 200 < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 699) == 0);
            cyc(1);
        end
        reset = 0;
        cyc(2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
